// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between instruction fetch and the load/store path;
//           data has priority, a streak limiter stops fetch starvation.
// Latency : request in IDLE at cycle 0, m_req from cycle 1, ack one cycle after m_ack.
// Backpressure: requesters hold req/payload until their ack; memory may stall ISSUE.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   if_req/if_addr         fetch request + address      -> if_rdata/if_ack/if_err
//   d_req/d_we/d_ctrl/...  data request + payload        -> d_rdata/d_ack/d_err
//   m_req/m_we/m_ctrl/...  registered memory request     <- m_rdata/m_ack
//   busy                   high whenever a transfer is in flight
//
// Optional build macro: MEM_TIMEOUT_EN adds an ISSUE watchdog that aborts a transfer
// after TIMEOUT cycles and reports it through if_err/d_err. Without it ISSUE waits
// indefinitely and the error outputs are tied low.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_ctrl,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [2:0]    m_ctrl,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          busy
);

  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_streak
    $error("mem_port_arbiter: MAX_D_STREAK out of range 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT out of range 1..1023");
  end

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state, state_nxt;
  logic       owner_d;   // 1 = data path owns the current transfer
  logic [3:0] streak;    // consecutive data grants taken while fetch was waiting
  logic       grant_d;
  logic       to_hit;    // watchdog expiry in this ISSUE cycle (never with m_ack)
  logic       err_q;

  // Data wins unless fetch is waiting and data has used up its streak.
  assign grant_d = d_req && (!if_req || (streak < MAX_S));

`ifdef MEM_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
  logic [9:0] to_cnt;

  // Held at zero in IDLE so it starts from zero on every ISSUE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 to_cnt <= '0;
    else if (state == IDLE)  to_cnt <= '0;
    else if (state == ISSUE) to_cnt <= to_cnt + 10'd1;
  end

  assign to_hit = (state == ISSUE) && !m_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_q <= 1'b0;
    else if (state == IDLE)  err_q <= 1'b0;
    else if (to_hit)         err_q <= 1'b1;
  end
`else
  assign to_hit = 1'b0;
  assign err_q  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || d_req) state_nxt = ISSUE;
      ISSUE:   if (m_ack || to_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      streak   <= '0;
      owner_d  <= 1'b0;
      m_we     <= 1'b0;
      m_ctrl   <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d <= 1'b1;
            m_we    <= d_we;
            m_ctrl  <= d_ctrl;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            // Only count the streak while fetch is actually being held off.
            if (!if_req)              streak <= '0;
            else if (streak != MAX_S) streak <= streak + 4'd1;
          end else if (if_req) begin
            owner_d <= 1'b0;
            m_we    <= 1'b0;
            m_ctrl  <= 3'b010;
            m_addr  <= if_addr;
            m_wdata <= '0;
            streak  <= '0;
          end
        end
        ISSUE: begin
          if (m_ack) begin
            if (owner_d) d_rdata  <= m_rdata;
            else         if_rdata <= m_rdata;
          end else if (to_hit) begin
            if (owner_d) d_rdata  <= '0;
            else         if_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded straight from state so an async reset drops m_req immediately.
  assign m_req  = (state == ISSUE);
  assign busy   = (state != IDLE);
  assign if_ack = (state == RESP) && !owner_d;
  assign d_ack  = (state == RESP) &&  owner_d;
  assign if_err = if_ack && err_q;
  assign d_err  = d_ack  && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MAXS = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int TB_TO = 8;
`else
  localparam int TB_TO = 255;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, if_ack, if_err;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic d_req = 0, d_we = 0, d_ack, d_err;
  logic [2:0] d_ctrl = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0, d_rdata;
  logic m_req, m_we, m_ack = 0, busy;
  logic [2:0] m_ctrl;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata = '0;

  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_ctrl(d_ctrl), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_ctrl(m_ctrl), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transfer is either absent, waiting for memory, or completed (one ack cycle).
  bit md_act, md_done, md_own_d, md_err;
  int md_wait, md_run;
  logic md_we;
  logic [2:0] md_ctrl;
  logic [AW-1:0] md_addr;
  logic [DW-1:0] md_wdata, md_ifr, md_dr;
  bit grants[$];   // 1 = data grant, 0 = fetch grant

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_act = 0; md_done = 0; md_own_d = 0; md_err = 0; md_run = 0; md_wait = 0;
      md_we = 0; md_ctrl = 0; md_addr = 0; md_wdata = 0; md_ifr = 0; md_dr = 0;
    end else if (!md_act) begin
      if (d_req && (!if_req || md_run < MAXS)) begin
        md_own_d = 1;
        md_run = if_req ? md_run + 1 : 0;
        md_we = d_we; md_ctrl = d_ctrl; md_addr = d_addr; md_wdata = d_wdata;
        grants.push_back(1'b1);
      end else if (if_req) begin
        md_own_d = 0; md_run = 0;
        md_we = 0; md_ctrl = 3'b010; md_addr = if_addr; md_wdata = 0;
        grants.push_back(1'b0);
      end
      if (if_req || d_req) begin md_act = 1; md_done = 0; md_err = 0; md_wait = 0; end
    end else if (!md_done) begin
      md_wait++;
      if (m_ack) begin
        md_done = 1;
        if (md_own_d) md_dr = m_rdata; else md_ifr = m_rdata;
      end
`ifdef MEM_TIMEOUT_EN
      else if (md_wait == TB_TO) begin
        md_done = 1; md_err = 1;
        if (md_own_d) md_dr = 0; else md_ifr = 0;
      end
`endif
    end else begin
      md_act = 0;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, md_act);
    chk("m_req", m_req, md_act && !md_done);
    chk("m_payload", {m_we, m_ctrl, m_addr, m_wdata}, {md_we, md_ctrl, md_addr, md_wdata});
    chk("if_ack", if_ack, md_act && md_done && !md_own_d);
    chk("d_ack", d_ack, md_act && md_done && md_own_d);
    chk("if_err", if_err, md_act && md_done && !md_own_d && md_err);
    chk("d_err", d_err, md_act && md_done && md_own_d && md_err);
    chk("if_rdata", if_rdata, md_ifr);
    chk("d_rdata", d_rdata, md_dr);
    chk("ack_exclusive", if_ack && d_ack, 1'b0);
  end

  // ---------------- memory responder ----------------
  int mem_delay = 2, mcnt = 0;
  bit mem_rand = 0, mem_noack = 0, spur_en = 0, mem_fix = 1;
  logic [DW-1:0] mem_word = 32'hDEADBEEF;

  initial forever begin
    @(posedge clk); #1;
    m_ack = 0;
    if (m_req) begin
      if (!mem_noack && mcnt == mem_delay) begin
        m_ack = 1;
        m_rdata = mem_fix ? mem_word : $urandom;
      end
      mcnt++;
    end else begin
      mcnt = 0;
      if (mem_rand) mem_delay = $urandom_range(0, 3);
      if (spur_en && $urandom_range(0, 2) == 0) begin m_ack = 1; m_rdata = $urandom; end
    end
  end

  // ---------------- requester driver ----------------
  int mode = 0;   // 0 hold-until-ack only, 1 random, 2 always requesting
  task automatic new_d();
    d_ctrl = 3'($urandom_range(0, 7));
    d_we = (d_ctrl >= 3'd5);
    d_addr = $urandom; d_wdata = $urandom; d_req = 1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (if_ack) if_req = 0;
    if (d_ack) d_req = 0;
    if (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0))
      if (!if_req) begin if_req = 1; if_addr = $urandom; end
    if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0))
      if (!d_req) new_d();
  end

  task automatic wait_mreq(input string name);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (m_req) begin ok = 1; break; end
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic wait_mack(input string name);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (m_ack) begin ok = 1; break; end
      @(posedge clk); #2;
    end
    chk(name, ok, 1'b1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    string pat;
    int n;
    pat = "DDDDFDDDDF";
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", {busy, m_req, if_ack, d_ack, if_err, d_err}, 6'b0);
    chk("reset_regs", {m_we, m_ctrl, m_addr, m_wdata, if_rdata, d_rdata}, 0);
    @(posedge clk); #1 rst = 0;

    // Fetch only, memory acks 2 cycles after m_req.
    @(posedge clk); #2 if_req = 1; if_addr = 32'h100;
    wait_mreq("fetch_mreq_seen");
    chk("fetch_payload", {m_we, m_ctrl, m_addr}, {1'b0, 3'b010, 32'h100});
    wait_mack("fetch_mack_seen");
    @(posedge clk); #2;
    chk("fetch_ack", {if_ack, d_ack}, 2'b10);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
    @(posedge clk); #2;
    chk("fetch_busy_low", busy, 1'b0);

    // Store only.
    @(posedge clk); #2;
    d_req = 1; d_we = 1; d_ctrl = 3'b101; d_addr = 32'h2003; d_wdata = 32'hAB;
    wait_mreq("store_mreq_seen");
    chk("store_payload", {m_we, m_ctrl, m_addr, m_wdata}, {1'b1, 3'b101, 32'h2003, 32'hAB});
    wait_mack("store_mack_seen");
    @(posedge clk); #2;
    chk("store_ack", {if_ack, d_ack}, 2'b01);

    // Stray m_ack pulses while idle must be ignored.
    spur_en = 1; mem_fix = 0;
    repeat (12) @(posedge clk);
    #2 spur_en = 0;
    chk("spur_idle_busy", busy, 1'b0);

    // Reset in the middle of ISSUE.
    mem_noack = 1;
    @(posedge clk); #2;
    d_req = 1; d_we = 0; d_ctrl = 3'b010; d_addr = 32'h40; d_wdata = 0;
    wait_mreq("rst_mreq_seen");
    @(posedge clk); #2 rst = 1; d_req = 0;
    #1;
    chk("rst_async_mreq", m_req, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    @(posedge clk); #3 rst = 0; mem_noack = 0;
    repeat (3) @(posedge clk);

    // Contention with both requesters always active.
    mem_rand = 1;
    @(posedge clk); #2;
    grants.delete();
    mode = 2;
    for (int i = 0; i < 300 && grants.size() < 10; i++) @(posedge clk);
    #2 mode = 0;
    chk("grant_count", grants.size() >= 10, 1'b1);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      chk("grant_order", grants[i], pat[i] == "D");
    repeat (30) @(posedge clk);

    // Randomized traffic with random latency and stray m_ack pulses.
    #2 mode = 1; spur_en = 1;
    repeat (1500) @(posedge clk);
    #2 mode = 0; spur_en = 0;
    repeat (30) @(posedge clk);

`ifdef MEM_TIMEOUT_EN
    // Watchdog expiry with no m_ack.
    mem_rand = 0; mem_noack = 1;
    @(posedge clk); #2;
    d_req = 1; d_we = 1; d_ctrl = 3'b111; d_addr = 32'h80; d_wdata = 32'h5;
    wait_mreq("to_mreq_seen");
    n = 0;
    while (m_req && n < 100) begin n++; @(posedge clk); #2; end
    chk("to_mreq_cycles", n, 8);
    chk("to_ack_err", {d_ack, d_err}, 2'b11);
    chk("to_rdata", d_rdata, 0);
    repeat (3) @(posedge clk);

    // m_ack on the expiry cycle wins.
    mem_noack = 0; mem_delay = 7; mem_fix = 1; mem_word = 32'h12345678;
    @(posedge clk); #2;
    d_req = 1; d_we = 0; d_ctrl = 3'b010; d_addr = 32'h84;
    wait_mreq("to2_mreq_seen");
    n = 0;
    while (m_req && n < 100) begin n++; @(posedge clk); #2; end
    chk("to2_mreq_cycles", n, 8);
    chk("to2_ack_err", {d_ack, d_err}, 2'b10);
    chk("to2_rdata", d_rdata, 32'h12345678);
    repeat (3) @(posedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
